// File: rtl/ins_fetch_ctrl_pkg.sv
// Shared CPU constants for the fetch, decode and ROM blocks.
//   CPU_ADDR_W   : instruction ROM word-address width (64 words)
//   CPU_INS_W    : instruction width
//   CPU_CNT_W    : fetch counter width
//   CPU_HALT_INS : ARM "B ." self-branch; fetching it stops sequencing
//   fetch_state_e: fetch sequencer states
package ins_fetch_ctrl_pkg;

  localparam int unsigned CPU_ADDR_W = 6;
  localparam int unsigned CPU_INS_W  = 32;
  localparam int unsigned CPU_CNT_W  = 16;

  localparam logic [CPU_INS_W-1:0] CPU_HALT_INS = 32'hEAFF_FFFE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ins_fetch_ctrl.sv
// Instruction-fetch sequencer for the asynchronous-read instruction ROM.
// Owns the PC, drives the ROM address and registers each fetched word into a
// one-entry output stage handshaked to decode (valid/ready).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : leave IDLE and begin fetching at current PC
//   rom_addr / rom_ins   : ROM address (= PC) and same-cycle ROM data
//   ins_out/ins_pc/ins_valid/ins_ready : output stage to decode
//   redirect_en/redirect_pc : taken branch; flushes the stage, reloads PC
//   busy / halted        : state is FETCH / HALT
//   wrap                 : one-cycle pulse after the PC wrapped to 0
//   fetch_cnt            : saturating count of fetched words
module ins_fetch_ctrl
  import ins_fetch_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_W   = CPU_ADDR_W,
  parameter int unsigned          INS_W    = CPU_INS_W,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [INS_W-1:0]     HALT_INS = CPU_HALT_INS,
  parameter int unsigned          CNT_W    = CPU_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INS_W-1:0]  rom_ins,
  output logic [INS_W-1:0]  ins_out,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              halted,
  output logic              wrap,
  output logic [CNT_W-1:0]  fetch_cnt
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INS_W-1:0]  ins_out_q, ins_out_d;
  logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;
  logic              ins_valid_q, ins_valid_d;
  logic              wrap_q, wrap_d;
  logic              busy_q, halted_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic acc, free, fetch, is_halt;

  assign acc     = ins_valid_q & ins_ready;
  assign free    = ~ins_valid_q | ins_ready;
  assign fetch   = (state_q == ST_FETCH) & free & ~redirect_en;
  assign is_halt = (rom_ins == HALT_INS);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_out_d   = ins_out_q;
    ins_pc_d    = ins_pc_q;
    ins_valid_d = ins_valid_q;
    wrap_d      = 1'b0;
    cnt_d       = cnt_q;

    if (redirect_en) begin
      // Flush wins over any pending acceptance; target fetched next edge.
      state_d     = ST_FETCH;
      pc_d        = redirect_pc;
      ins_valid_d = 1'b0;
    end else if (fetch) begin
      ins_out_d   = rom_ins;
      ins_pc_d    = pc_q;
      ins_valid_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (is_halt) begin
        // PC stays parked on the halt word's address.
        state_d = ST_HALT;
      end else begin
        pc_d   = pc_q + ADDR_W'(1);
        wrap_d = (pc_q == '1);
      end
    end else begin
      if (acc) begin
        ins_valid_d = 1'b0;
      end
      if (state_q == ST_IDLE && start) begin
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      ins_out_q   <= '0;
      ins_pc_q    <= '0;
      ins_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_out_q   <= ins_out_d;
      ins_pc_q    <= ins_pc_d;
      ins_valid_q <= ins_valid_d;
      wrap_q      <= wrap_d;
      cnt_q       <= cnt_d;
      busy_q      <= (state_d == ST_FETCH);
      halted_q    <= (state_d == ST_HALT);
    end
  end

  assign rom_addr  = pc_q;
  assign ins_out   = ins_out_q;
  assign ins_pc    = ins_pc_q;
  assign ins_valid = ins_valid_q;
  assign wrap      = wrap_q;
  assign fetch_cnt = cnt_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Bench for ins_fetch_ctrl: directed stimulus, a cycle-level reference model
// of the fetch sequencer checked every cycle, plus literal spot checks.
module tb_ins_fetch_ctrl;

  localparam logic [31:0] HALT = 32'hEAFF_FFFE;

  logic        clk = 1'b0;
  logic        rst, start, ins_ready, redirect_en;
  logic [5:0]  redirect_pc;
  logic [5:0]  rom_addr, ins_pc;
  logic [31:0] rom_ins, ins_out;
  logic        ins_valid, busy, halted, wrap;
  logic [15:0] fetch_cnt;

  logic [31:0] rom [64];
  assign rom_ins = rom[rom_addr];

  always #5 clk = ~clk;

  ins_fetch_ctrl #(.ADDR_W(6), .INS_W(32), .RESET_PC(6'd0), .HALT_INS(HALT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rom_addr(rom_addr), .rom_ins(rom_ins),
    .ins_out(ins_out), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .busy(busy), .halted(halted), .wrap(wrap), .fetch_cnt(fetch_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: "mode" 0 = idle, 1 = running, 2 = stopped on halt word.
  int          m_mode;
  int          m_pc, m_ipc, m_cnt;
  logic [31:0] m_out;
  bit          m_val, m_wrap, m_live = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_pc = 0; m_ipc = 0; m_out = 0;
      m_val = 0; m_wrap = 0; m_cnt = 0; m_live = 1;
    end else if (m_live) begin
      m_wrap = 0;
      if (redirect_en) begin
        m_mode = 1; m_pc = int'(redirect_pc); m_val = 0;
      end else if (m_mode == 1 && (!m_val || ins_ready)) begin
        m_out = rom[m_pc]; m_ipc = m_pc; m_val = 1;
        m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
        if (m_out == HALT) m_mode = 2;
        else begin
          m_wrap = (m_pc == 63);
          m_pc = (m_pc + 1) % 64;
        end
      end else begin
        if (m_val && ins_ready) m_val = 0;
        if (m_mode == 0 && start) m_mode = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("rom_addr",  64'(rom_addr),  64'(m_pc));
      chk("ins_valid", 64'(ins_valid), 64'(m_val));
      chk("ins_out",   64'(ins_out),   64'(m_out));
      chk("ins_pc",    64'(ins_pc),    64'(m_ipc));
      chk("busy",      64'(busy),      64'(m_mode == 1));
      chk("halted",    64'(halted),    64'(m_mode == 2));
      chk("wrap",      64'(wrap),      64'(m_wrap));
      chk("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + 32'(i);
    rom[0] = 32'hE3A0_0001; rom[1] = 32'hE3A0_1002;
    rom[2] = 32'hE080_2001; rom[3] = HALT;
    rst = 1; start = 0; ins_ready = 1; redirect_en = 0; redirect_pc = '0;
    step(2);
    rst = 0;
    chk("rst_valid", 64'(ins_valid), 64'd0);
    chk("rst_cnt", 64'(fetch_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    step(2);
    chk("idle_no_start", 64'(ins_valid), 64'd0);

    // Straight-line run to the halt word.
    start = 1; step(1); start = 0;
    chk("start_busy", 64'(busy), 64'd1);
    step(1);
    chk("first_pc", 64'(ins_pc), 64'd0);
    chk("first_ins", 64'(ins_out), 64'hE3A0_0001);
    step(1);
    chk("second_ins", 64'(ins_out), 64'hE3A0_1002);
    step(2);
    chk("halt_pc", 64'(ins_pc), 64'd3);
    chk("halted", 64'(halted), 64'd1);
    chk("halt_cnt", 64'(fetch_cnt), 64'd4);
    chk("model_cnt", 64'(m_cnt), 64'd4);
    chk("halt_rom_addr", 64'(rom_addr), 64'd3);
    step(1);
    chk("halt_drop", 64'(ins_valid), 64'd0);

    // Backpressure while ins_pc=1 is presented.
    redirect_en = 1; redirect_pc = 6'd0; step(1); redirect_en = 0;
    step(2);
    chk("bp_pc1", 64'(ins_pc), 64'd1);
    ins_ready = 0; step(3);
    chk("bp_hold_pc", 64'(ins_pc), 64'd1);
    chk("bp_hold_ins", 64'(ins_out), 64'hE3A0_1002);
    chk("bp_rom_addr", 64'(rom_addr), 64'd2);
    chk("bp_cnt", 64'(fetch_cnt), 64'd6);
    ins_ready = 1; step(1);
    chk("bp_release", 64'(ins_pc), 64'd2);
    step(3);

    // Redirect flush while ins_pc=5 is stalled.
    redirect_en = 1; redirect_pc = 6'd4; step(1); redirect_en = 0;
    step(2);
    chk("pre_redir_pc", 64'(ins_pc), 64'd5);
    ins_ready = 0; step(1);
    redirect_en = 1; redirect_pc = 6'd40; step(1); redirect_en = 0;
    chk("redir_flush", 64'(ins_valid), 64'd0);
    chk("redir_pc", 64'(rom_addr), 64'd40);
    step(1);
    chk("redir_target", 64'(ins_pc), 64'd40);
    chk("redir_valid", 64'(ins_valid), 64'd1);
    ins_ready = 1; step(2);

    // Wrap 62 -> 63 -> 0.
    redirect_en = 1; redirect_pc = 6'd62; step(1); redirect_en = 0;
    chk("redir_nowrap", 64'(wrap), 64'd0);
    step(1);
    chk("wrap_62", 64'(ins_pc), 64'd62);
    step(1);
    chk("wrap_63", 64'(ins_pc), 64'd63);
    chk("wrap_pulse", 64'(wrap), 64'd1);
    chk("wrap_rom_addr", 64'(rom_addr), 64'd0);
    step(1);
    chk("wrap_0", 64'(ins_pc), 64'd0);
    chk("wrap_end", 64'(wrap), 64'd0);
    step(5);
    chk("halt2", 64'(halted), 64'd1);

    // HALT exit: start ignored, redirect leaves.
    start = 1; step(2); start = 0;
    chk("halt_start_ign", 64'(halted), 64'd1);
    chk("halt_pc_frozen", 64'(rom_addr), 64'd3);
    redirect_en = 1; redirect_pc = 6'd10; step(1); redirect_en = 0;
    chk("exit_halted", 64'(halted), 64'd0);
    chk("exit_busy", 64'(busy), 64'd1);
    step(1);
    chk("exit_target", 64'(ins_pc), 64'd10);

    // Redirect and start together in IDLE after a mid-stream reset.
    step(2);
    chk("stream_valid", 64'(ins_valid), 64'd1);
    rst = 1; step(1); rst = 0;
    chk("mrst_valid", 64'(ins_valid), 64'd0);
    chk("mrst_pc", 64'(rom_addr), 64'd0);
    chk("mrst_ins", 64'(ins_out), 64'd0);
    chk("mrst_cnt", 64'(fetch_cnt), 64'd0);
    step(3);
    chk("mrst_idle", 64'(busy), 64'd0);
    start = 1; step(1); start = 0; step(1);
    chk("resume_pc", 64'(ins_pc), 64'd0);
    step(4);
    start = 1; redirect_en = 1; redirect_pc = 6'd20; step(1);
    start = 0; redirect_en = 0;
    step(1);
    chk("redir_start_pc", 64'(ins_pc), 64'd20);
    rst = 1; step(1); rst = 0;
    start = 1; redirect_en = 1; redirect_pc = 6'd30; step(1);
    start = 0; redirect_en = 0; step(1);
    chk("idle_redir_start", 64'(ins_pc), 64'd30);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
